id_issue_buffer: RTL

ID_ISSUE_BUFFER -- requirements
Module: id_issue_buffer

---
 rtl/id_issue_buffer_if.sv | 33 +++
 rtl/id_issue_buffer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/id_issue_buffer_if.sv
// Fetch, issue, regfile-read and forwarding signals between ID and its neighbours.
// master = surrounding pipeline (fetch/EX/regfile), slave = the issue buffer.
interface id_issue_buffer_if #(
    parameter int NFWD = 3
);
    logic                 fetch_valid;
    logic [31:0]          fetch_pc;
    logic [31:0]          fetch_inst;
    logic                 fetch_ready;
    logic                 issue_ready;
    logic                 issue_valid;
    logic [31:0]          issue_pc;
    logic [31:0]          issue_inst;
    logic [31:0]          rf_rdata1;
    logic [31:0]          rf_rdata2;
    logic [NFWD-1:0]      fwd_we;
    logic [5*NFWD-1:0]    fwd_waddr;
    logic [32*NFWD-1:0]   fwd_wdata;
    logic [31:0]          src1_data;
    logic [31:0]          src2_data;

    modport slave (
        input  fetch_valid, fetch_pc, fetch_inst, issue_ready,
               rf_rdata1, rf_rdata2, fwd_we, fwd_waddr, fwd_wdata,
        output fetch_ready, issue_valid, issue_pc, issue_inst, src1_data, src2_data
    );

    modport master (
        output fetch_valid, fetch_pc, fetch_inst, issue_ready,
               rf_rdata1, rf_rdata2, fwd_we, fwd_waddr, fwd_wdata,
        input  fetch_ready, issue_valid, issue_pc, issue_inst, src1_data, src2_data
    );
endinterface

// File: rtl/id_issue_buffer.sv
// Decode-stage instruction buffer: circular FIFO, load-use interlock via a
// short issue scoreboard, and operand forwarding for the head instruction.
module id_issue_buffer #(
    parameter int DEPTH    = 4,
    parameter int NFWD     = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    id_issue_buffer_if.slave       bus,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [15:0]            hazard_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic [31:0]      pc_mem_q [DEPTH];
    logic [31:0]      pc_mem_d [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];
    logic [31:0]      inst_mem_d [DEPTH];
    logic [LOAD_LAT-1:0]      sb_vld_q, sb_vld_d;
    logic [LOAD_LAT-1:0][4:0] sb_addr_q, sb_addr_d;
    logic [15:0]      hazard_cnt_q, hazard_cnt_d;

    logic [31:0] head_inst;
    logic [4:0]  rs, rt;
    logic        not_empty, is_load, sb_hit, hazard, push, pop;
    logic        fetch_ready, issue_valid;
    logic [31:0] src1, src2;

    assign head_inst = inst_mem_q[rd_ptr_q];
    assign rs        = head_inst[25:21];
    assign rt        = head_inst[20:16];
    assign is_load   = (head_inst[31:29] == 3'b100);
    assign not_empty = (occ_q != '0);

    always_comb begin
        sb_hit = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (sb_vld_q[i] && ((rs != 5'd0 && rs == sb_addr_q[i]) ||
                                (rt != 5'd0 && rt == sb_addr_q[i])))
                sb_hit = 1'b1;
        end
    end

    assign hazard      = not_empty & sb_hit;
    assign issue_valid = not_empty & ~hazard & ~flush;
    // A full buffer refuses fetch even when the head pops the same cycle.
    assign fetch_ready = (occ_q < FULL);
    assign push        = bus.fetch_valid & fetch_ready & ~flush;
    assign pop         = issue_valid & bus.issue_ready;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        occ_d      = occ_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        if (push) begin
            pc_mem_d[wr_ptr_q]   = bus.fetch_pc;
            inst_mem_d[wr_ptr_q] = bus.fetch_inst;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + (PTR_W+1)'(1);
            2'b01:   occ_d = occ_q - (PTR_W+1)'(1);
            default: occ_d = occ_q;
        endcase
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end
    end

    // Scoreboard keeps shifting through flush: an issued load is still in flight.
    always_comb begin
        sb_vld_d  = '0;
        sb_addr_d = '0;
        for (int i = 1; i < LOAD_LAT; i++) begin
            sb_vld_d[i]  = sb_vld_q[i-1];
            sb_addr_d[i] = sb_addr_q[i-1];
        end
        if (pop && is_load && rt != 5'd0) begin
            sb_vld_d[0]  = 1'b1;
            sb_addr_d[0] = rt;
        end
    end

    always_comb begin
        hazard_cnt_d = hazard_cnt_q;
        if (hazard && bus.issue_ready && hazard_cnt_q != 16'hFFFF)
            hazard_cnt_d = hazard_cnt_q + 16'd1;
    end

    // Scan youngest-last so the lowest-index matching source wins.
    always_comb begin
        src1 = bus.rf_rdata1;
        src2 = bus.rf_rdata2;
        for (int i = NFWD-1; i >= 0; i--) begin
            if (bus.fwd_we[i] && bus.fwd_waddr[5*i +: 5] == rs) src1 = bus.fwd_wdata[32*i +: 32];
            if (bus.fwd_we[i] && bus.fwd_waddr[5*i +: 5] == rt) src2 = bus.fwd_wdata[32*i +: 32];
        end
        if (rs == 5'd0) src1 = '0;
        if (rt == 5'd0) src2 = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            occ_q        <= '0;
            sb_vld_q     <= '0;
            sb_addr_q    <= '0;
            hazard_cnt_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            occ_q        <= occ_d;
            sb_vld_q     <= sb_vld_d;
            sb_addr_q    <= sb_addr_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_mem_q   <= pc_mem_d;
        inst_mem_q <= inst_mem_d;
    end

    assign bus.fetch_ready = fetch_ready;
    assign bus.issue_valid = issue_valid;
    assign bus.issue_pc    = pc_mem_q[rd_ptr_q];
    assign bus.issue_inst  = head_inst;
    assign bus.src1_data   = src1;
    assign bus.src2_data   = src2;
    assign occupancy       = occ_q;
    assign hazard_cnt      = hazard_cnt_q;
endmodule
